// File: rtl/data_mem_responder_pkg.sv
// Shared types and defaults for the data-memory responder: FSM state encoding,
// data width and the default geometry/wait-state parameters.
package data_mem_responder_pkg;

  localparam int DATA_WIDTH          = 16;
  localparam int DEFAULT_ADDR_WIDTH  = 8;
  localparam int DEFAULT_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/data_mem_responder_mem_array.sv
// Single-port synchronous word RAM with write enable and a registered,
// write-first read port (a store returns the written word).
module data_mem_responder_mem_array
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Array has no reset so contents survive a reset of the responder.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= we ? wdata : mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's LOAD/STORE interface: one request at a
// time, WAIT_CYCLES wait states, one response per request. Optional alignment
// checking is enabled by defining MEM_ALIGN_CHECK_EN.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [15:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_busy,
  output state_t                fsm_state
);

  // Handshakes: a request transfers on an edge with req_valid && req_ready,
  // a response transfers on an edge with rsp_valid && rsp_ready; the payload
  // on either side must be held stable until the transfer edge.

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t                state, next_state;
  logic [3:0]            cnt;
  logic                  lat_write;
  logic [ADDR_WIDTH-1:0] lat_index;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic                  lat_odd;
  logic                  err_q;
  logic                  access;
  logic                  misaligned;
  logic                  ram_en;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  unused_addr;

  // WAIT holds WAIT_CYCLES idle cycles; the access happens on the edge that
  // leaves WAIT with the counter exhausted, giving latency WAIT_CYCLES + 1.
  always_comb begin
    next_state = state;
    access     = 1'b0;
    case (state)
      ST_IDLE: if (req_valid) next_state = ST_WAIT;
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          access     = 1'b1;
          next_state = ST_RESP;
        end
      end
      ST_RESP: if (rsp_ready) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      lat_write <= 1'b0;
      lat_index <= '0;
      lat_wdata <= '0;
      lat_odd   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ST_IDLE && req_valid) begin
        lat_write <= req_write;
        lat_index <= req_addr[ADDR_WIDTH:1];
        lat_wdata <= req_wdata;
        lat_odd   <= req_addr[0];
        cnt       <= WAIT_INIT;
      end else if (state == ST_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        err_q <= misaligned;
      end
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = lat_odd;
`else
  logic unused_odd;
  assign misaligned = 1'b0;
  assign unused_odd = lat_odd;
`endif

  // Reset gates the enable so a store still in flight is never committed.
  assign ram_en      = access && !misaligned && !reset;
  assign unused_addr = ^req_addr[15:ADDR_WIDTH+1];

  data_mem_responder_mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem_array (
    .clk   (clk),
    .reset (reset),
    .en    (ram_en),
    .we    (lat_write),
    .addr  (lat_index),
    .wdata (lat_wdata),
    .rdata (ram_rdata)
  );

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign mem_busy  = (state != ST_IDLE);
  assign rsp_err   = err_q;
  assign rsp_rdata = err_q ? '0 : ram_rdata;
  assign fsm_state = state;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: table of request vectors against a
// WAIT_CYCLES=2 instance, plus hand sequences for reset and zero wait states.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam int W = 2;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          hold;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        req_valid, req_write, req_ready, rsp_valid, rsp_ready, rsp_err, mem_busy;
  logic [15:0] req_addr, req_wdata, rsp_rdata;
  state_t      fsm_state;

  logic        z_req_valid, z_req_write, z_req_ready, z_rsp_valid, z_rsp_ready, z_rsp_err, z_mem_busy;
  logic [15:0] z_req_addr, z_req_wdata, z_rsp_rdata;
  state_t      z_fsm_state;

  int checks = 0;
  int errors = 0;
  vec_t vecs[12];

  data_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_busy(mem_busy), .fsm_state(fsm_state)
  );

  data_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_ready(z_req_ready),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
    .rsp_err(z_rsp_err), .mem_busy(z_mem_busy), .fsm_state(z_fsm_state)
  );

  // Clock and time limit
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver for the WAIT_CYCLES=W instance; checks exact latency and hold.
  task automatic do_req(input vec_t v);
    req_valid = 1'b1;
    req_write = v.write;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    rsp_ready = (v.hold == 0);
    check("accept_ready", 16'(req_ready), 16'h1);
    tick;
    req_valid = 1'b0;
    req_write = ~v.write;
    req_addr  = v.addr ^ 16'h00fe;
    req_wdata = ~v.wdata;
    check("busy_after_accept", 16'(mem_busy), 16'h1);
    check("ready_after_accept", 16'(req_ready), 16'h0);
    for (int i = 0; i <= W; i++) begin
      check("early_valid", 16'(rsp_valid), 16'h0);
      tick;
    end
    check("rsp_valid", 16'(rsp_valid), 16'h1);
    check("rsp_rdata", rsp_rdata, v.exp_rdata);
    check("rsp_err", 16'(rsp_err), 16'(v.exp_err));
    for (int h = 0; h < v.hold; h++) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 16'h0010;
      req_wdata = 16'hdead;
      tick;
      check("hold_valid", 16'(rsp_valid), 16'h1);
      check("hold_rdata", rsp_rdata, v.exp_rdata);
      check("hold_busy", 16'(mem_busy), 16'h1);
      check("hold_ready", 16'(req_ready), 16'h0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick;
    check("release_valid", 16'(rsp_valid), 16'h0);
    check("release_ready", 16'(req_ready), 16'h1);
    check("release_busy", 16'(mem_busy), 16'h0);
    check("release_rdata", rsp_rdata, v.exp_rdata);
  endtask

  // Driver for the zero-wait instance: response must follow the next edge.
  task automatic do_req0(input logic write, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] exp);
    z_req_valid = 1'b1;
    z_req_write = write;
    z_req_addr  = addr;
    z_req_wdata = wdata;
    z_rsp_ready = 1'b1;
    tick;
    z_req_valid = 1'b0;
    check("w0_early_valid", 16'(z_rsp_valid), 16'h0);
    check("w0_busy", 16'(z_mem_busy), 16'h1);
    tick;
    check("w0_rsp_valid", 16'(z_rsp_valid), 16'h1);
    check("w0_rsp_rdata", z_rsp_rdata, exp);
    tick;
    check("w0_release_ready", 16'(z_req_ready), 16'h1);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 16'h0010, 16'hcafe, 0, 16'hcafe, 1'b0};
    vecs[1]  = '{1'b0, 16'h0010, 16'h0000, 0, 16'hcafe, 1'b0};
    vecs[2]  = '{1'b0, 16'h0010, 16'h0000, 4, 16'hcafe, 1'b0};
    vecs[3]  = '{1'b0, 16'h0010, 16'h0000, 0, 16'hcafe, 1'b0};
    vecs[4]  = '{1'b1, 16'h0202, 16'h1234, 0, 16'h1234, 1'b0};
    vecs[5]  = '{1'b0, 16'h0002, 16'h0000, 1, 16'h1234, 1'b0};
    vecs[6]  = '{1'b0, 16'hfe02, 16'h0000, 0, 16'h1234, 1'b0};
    vecs[7]  = '{1'b1, 16'h0020, 16'h0000, 0, 16'h0000, 1'b0};
    vecs[8]  = '{1'b1, 16'h0011, 16'hbeef, 0, ALIGN ? 16'h0000 : 16'hbeef, ALIGN};
    vecs[9]  = '{1'b0, 16'h0010, 16'h0000, 0, ALIGN ? 16'hcafe : 16'hbeef, 1'b0};
    vecs[10] = '{1'b1, 16'h01fe, 16'h7777, 2, 16'h7777, 1'b0};
    vecs[11] = '{1'b0, 16'h01fe, 16'h0000, 0, 16'h7777, 1'b0};

    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_rsp_ready = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    check("reset_req_ready", 16'(req_ready), 16'h1);
    check("reset_rsp_valid", 16'(rsp_valid), 16'h0);
    check("reset_rsp_rdata", rsp_rdata, 16'h0000);
    check("reset_rsp_err", 16'(rsp_err), 16'h0);
    check("reset_mem_busy", 16'(mem_busy), 16'h0);
    check("reset_state", 16'(fsm_state), 16'(ST_IDLE));

    for (int i = 0; i < 12; i++) begin
      do_req(vecs[i]);
    end

    // Reset while a store sits in WAIT: the store must be dropped.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0020; req_wdata = 16'h5555;
    tick;
    req_valid = 1'b0;
    tick;
    check("mid_wait_busy", 16'(mem_busy), 16'h1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("post_reset_ready", 16'(req_ready), 16'h1);
    check("post_reset_busy", 16'(mem_busy), 16'h0);
    check("post_reset_valid", 16'(rsp_valid), 16'h0);
    check("post_reset_rdata", rsp_rdata, 16'h0000);
    tick;
    check("post_reset_still_idle", 16'(fsm_state), 16'(ST_IDLE));
    do_req('{1'b0, 16'h0020, 16'h0000, 0, 16'h0000, 1'b0});

    do_req0(1'b1, 16'h0004, 16'ha5a5, 16'ha5a5);
    do_req0(1'b0, 16'h0004, 16'h0000, 16'ha5a5);
    do_req0(1'b1, 16'h0206, 16'h3c3c, 16'h3c3c);
    do_req0(1'b0, 16'h0006, 16'h0000, 16'h3c3c);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
